// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared types and constants for the CPU memory-bus arbiter.
//   bus_state_t : arbiter sequencing states (IDLE, CMD, RESP)
//   bus_owner_t : which requester holds the bus (OWN_IF fetch, OWN_D data)
//   HALT_ADDR   : fetching from this address halts the CPU
package cpu_bus_pkg;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam logic [31:0] HALT_ADDR  = 32'h0;

  typedef enum logic [1:0] {IDLE, CMD, RESP} bus_state_t;
  typedef enum logic       {OWN_IF, OWN_D}   bus_owner_t;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin winner select, purely combinational.
//   req_if, req_d    : pending requests
//   last_owner       : requester that won the previous grant
//   gnt_if, gnt_d    : one-hot winner (both 0 when nothing is pending)
module rr_arb2
  import cpu_bus_pkg::*;
(
  input  logic       req_if,
  input  logic       req_d,
  input  bus_owner_t last_owner,
  output logic       gnt_if,
  output logic       gnt_d
);
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (req_if && req_d) begin
      // tie goes to whoever did not win last time
      gnt_d  = (last_owner == OWN_IF);
      gnt_if = ~gnt_d;
    end else begin
      gnt_if = req_if;
      gnt_d  = req_d;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single Avalon-style memory master port between
// instruction fetch and data load/store, and detects the halt fetch.
//   clk, reset        : clock, synchronous active-high reset
//   if_*              : fetch request / accept / read response
//   d_*               : data request / accept / completion (+ load data)
//   halted            : sticky, set by a fetch from HALT_ADDR
//   mem_*             : registered bus command, held through waitrequest
// One transaction: accept (IDLE) -> command (CMD, 1 + wait cycles) ->
// response pulse (RESP) -> IDLE.
module mem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic                d_ready,
  output logic                d_resp,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                halted,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic                mem_waitrequest,
  input  logic [DATA_W-1:0]   mem_readdata
);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  bus_state_t          state_q, state_d;
  bus_owner_t          owner_q, owner_d;
  bus_owner_t          last_q,  last_d;
  logic                halted_q, halted_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic                gnt_if, gnt_d;

  rr_arb2 u_arb (
    .req_if     (if_req),
    .req_d      (d_req),
    .last_owner (last_q),
    .gnt_if     (gnt_if),
    .gnt_d      (gnt_d)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    halted_d = halted_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    if_ready = 1'b0;
    d_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!halted_q && (gnt_if || gnt_d)) begin
          owner_d = gnt_d ? OWN_D : OWN_IF;
          last_d  = gnt_d ? OWN_D : OWN_IF;
          if (gnt_if) begin
            if_ready = 1'b1;
            if (if_addr == ADDR_W'(HALT_ADDR)) begin
              // halt fetch: no bus cycle, answer with zero next cycle
              halted_d = 1'b1;
              state_d  = RESP;
            end else begin
              rd_d    = 1'b1;
              addr_d  = if_addr & ALIGN_MASK;
              be_d    = '1;
              state_d = CMD;
            end
          end else begin
            d_ready = 1'b1;
            rd_d    = ~d_write;
            wr_d    = d_write;
            addr_d  = d_addr & ALIGN_MASK;
            wdata_d = d_wdata;
            be_d    = d_byteenable;
            state_d = CMD;
          end
        end
      end
      CMD: begin
        if (!mem_waitrequest) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      last_q   <= OWN_IF;
      halted_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      halted_q <= halted_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

  assign mem_read       = rd_q;
  assign mem_write      = wr_q;
  assign mem_address    = addr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;
  assign halted         = halted_q;

  // read data is routed straight from the bus in the response cycle;
  // the halt response (halted already set) returns zero instead
  assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
  assign d_resp    = (state_q == RESP) && (owner_q == OWN_D);
  assign if_rdata  = (if_rvalid && !halted_q) ? mem_readdata : '0;
  assign d_rdata   = d_resp ? mem_readdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + randomized checks of mem_arbiter against a
// transaction-level model (winner choice, command payload, response timing).
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_write, mem_waitrequest;
  logic [31:0] if_addr, d_addr, d_wdata, mem_readdata;
  logic [3:0]  d_byteenable;
  logic        if_ready, if_rvalid, d_ready, d_resp, halted;
  logic        mem_read, mem_write;
  logic [31:0] if_rdata, d_rdata, mem_address, mem_writedata;
  logic [3:0]  mem_byteenable;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_ready;
  bit last_w;   // model: 0 = fetch won last, 1 = data won last
  bit halted_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_ready(d_ready), .d_resp(d_resp),
    .d_rdata(d_rdata), .halted(halted),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1 of an IDLE cycle with requests already applied.
  task automatic run_txn(input int waits);
    bit          w_d, halt, exp_rd, exp_wr;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_be;
    if (if_req && d_req) w_d = (last_w == 1'b0);
    else                 w_d = d_req;
    halt     = !w_d && (if_addr == 32'h0);
    exp_addr = (w_d ? d_addr : if_addr) & 32'hFFFF_FFFC;
    exp_rd   = !w_d || !d_write;
    exp_wr   = w_d && d_write;
    exp_be   = w_d ? d_byteenable : 4'hF;
    exp_wd   = d_wdata;
    @(negedge clk);
    chk("if_ready_t0", 32'(if_ready), 32'(!w_d));
    chk("d_ready_t0", 32'(d_ready), 32'(w_d));
    t_ready = cyc;
    last_w  = w_d;
    nxt();
    // winner drops its request and scribbles its payload: the DUT must
    // have latched everything at accept time
    if (w_d) begin
      d_req = 1'b0; d_addr = $urandom; d_wdata = $urandom;
      d_write = 1'($urandom); d_byteenable = 4'($urandom);
    end else begin
      if_req = 1'b0; if_addr = $urandom;
    end
    if (halt) begin
      @(negedge clk);
      chk("halt_rvalid", 32'(if_rvalid), 32'd1);
      chk("halt_rdata", if_rdata, 32'd0);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_nobus", 32'({mem_read, mem_write}), 32'd0);
      halted_m = 1'b1;
      nxt();
      return;
    end
    for (int k = 0; k <= waits; k++) begin
      mem_waitrequest = (k < waits);
      @(negedge clk);
      chk("cmd_read", 32'(mem_read), 32'(exp_rd));
      chk("cmd_write", 32'(mem_write), 32'(exp_wr));
      chk("cmd_addr", mem_address, exp_addr);
      chk("cmd_be", 32'(mem_byteenable), 32'(exp_be));
      if (exp_wr) chk("cmd_wdata", mem_writedata, exp_wd);
      chk("cmd_quiet", 32'({if_ready, d_ready, if_rvalid, d_resp}), 32'd0);
      nxt();
    end
    mem_waitrequest = 1'b0;
    @(negedge clk);
    chk("resp_cmd_off", 32'({mem_read, mem_write}), 32'd0);
    chk("resp_if", 32'(if_rvalid), 32'(!w_d));
    chk("resp_d", 32'(d_resp), 32'(w_d));
    chk("resp_noready", 32'({if_ready, d_ready}), 32'd0);
    if (!w_d) chk("if_rdata", if_rdata, mem_readdata);
    if (w_d && exp_rd) chk("d_rdata", d_rdata, mem_readdata);
    nxt();
  endtask

  initial begin
    int t_first;
    reset = 1'b1; if_req = 0; d_req = 0; d_write = 0; mem_waitrequest = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; d_byteenable = 0; mem_readdata = 0;
    last_w = 1'b0; halted_m = 1'b0;
    nxt(); nxt();
    @(negedge clk);
    chk("rst_ctrl", 32'({if_ready, d_ready, if_rvalid, d_resp, halted, mem_read, mem_write}), 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_wdata", mem_writedata, 32'd0);
    chk("rst_be", 32'(mem_byteenable), 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    nxt();
    reset = 1'b0;

    // tie from reset: data first, then alternation with both held
    if_req = 1; if_addr = 32'h100; d_req = 1; d_write = 0; d_addr = 32'h200;
    d_byteenable = 4'hF; mem_readdata = 32'h1111_2222;
    for (int k = 0; k < 4; k++) begin
      if (!if_req) begin if_req = 1; if_addr = 32'h100 + 32'(k * 4); end
      if (!d_req) begin d_req = 1; d_write = 0; d_addr = 32'h200 + 32'(k * 4); d_byteenable = 4'hF; end
      run_txn(0);
      chk("tie_order", 32'(last_w), 32'((k % 2) == 0));
    end
    run_txn(0); // drain the pending data request

    // single load, zero wait
    d_req = 1; d_write = 0; d_addr = 32'h1004; d_byteenable = 4'hF;
    mem_readdata = 32'hDEAD_BEEF;
    run_txn(0);

    // unaligned store with 3 wait states, response exactly once
    d_req = 1; d_write = 1; d_addr = 32'h2003; d_wdata = 32'hCAFE_F00D;
    d_byteenable = 4'b0011;
    run_txn(3);
    @(negedge clk);
    chk("store_one_resp", 32'(d_resp), 32'd0);
    nxt();

    // back-to-back fetches: second accept 3 cycles after the first
    if_req = 1; if_addr = 32'h4; mem_readdata = 32'h0000_0013;
    run_txn(0);
    t_first = t_ready;
    if_req = 1; if_addr = 32'h8;
    run_txn(0);
    chk("b2b_gap", 32'(t_ready - t_first), 32'd3);

    // randomized mix; a pending loser keeps its payload untouched
    for (int n = 0; n < 30; n++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1; if_addr = 32'($urandom_range(1, 4095)) << 2;
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1; d_write = 1'($urandom); d_addr = $urandom;
        d_wdata = $urandom; d_byteenable = 4'($urandom);
      end
      if (!if_req && !d_req) begin
        d_req = 1; d_write = 0; d_addr = $urandom; d_byteenable = 4'hF;
      end
      mem_readdata = $urandom;
      run_txn($urandom_range(0, 3));
    end
    while (if_req || d_req) run_txn($urandom_range(0, 2));

    // reset during a stalled read abandons it silently
    d_req = 1; d_write = 0; d_addr = 32'h3000; d_byteenable = 4'hF;
    @(negedge clk);
    chk("rst_mid_accept", 32'(d_ready), 32'd1);
    nxt();
    d_req = 0; mem_waitrequest = 1;
    @(negedge clk);
    chk("rst_mid_cmd", 32'(mem_read), 32'd1);
    reset = 1'b1;
    nxt();
    @(negedge clk);
    chk("rst_mid_read", 32'(mem_read), 32'd0);
    chk("rst_mid_addr", mem_address, 32'd0);
    chk("rst_mid_noresp", 32'({d_resp, if_rvalid}), 32'd0);
    nxt();
    reset = 1'b0; mem_waitrequest = 0; last_w = 1'b0;
    @(negedge clk);
    chk("rst_mid_noresp2", 32'({d_resp, if_rvalid}), 32'd0);
    nxt();
    // IDLE after reset: a tie goes to data again
    if_req = 1; if_addr = 32'h40; d_req = 1; d_write = 0; d_addr = 32'h44;
    mem_readdata = $urandom;
    run_txn(0);
    run_txn(1);

    // halt fetch, then data requests are never accepted
    if_req = 1; if_addr = 32'h0; mem_readdata = 32'hFFFF_FFFF;
    run_txn(0);
    d_req = 1; d_write = 0; d_addr = 32'h50;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("halted_no_ready", 32'({d_ready, if_ready, mem_read}), 32'd0);
      chk("halted_sticky", 32'(halted), 32'(halted_m));
      nxt();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
